count_run_ctrl: RTL and testbench
=================================

# count_run_ctrl

Run controller for the team's 8-bit free-running counter datapath: sequences start, pause, abort and terminal-count completion of a prescaled up-count and drives the count value onto `out_data`. Sits between the control/test logic and any consumer of the count, such as benches that print on `out_data[0]` changes and finish on `8'hFF`. It also produces the bit-0 change event and a completion pulse so observers need no edge detectors of their own.

## Interface
- `WIDTH`, 8: count width.
- `DIV`, 1: prescaler ratio; one count step every `DIV` clocks in RUN. Legal range is 1..256.
- `clk`  in  1  clock.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  pulse; loads `start_val` and begins counting.
- `stop`  in  1  pulse; aborts the run and returns to IDLE.
- `pause`  in  1  level; freezes counting and the prescaler while high.
- `start_val`  in  WIDTH  first count value, sampled on `start`.
- `term_val`  in  WIDTH  terminal value; must be held stable during a run.
- `out_data`  out  WIDTH  current count.
- `busy`  out  1  high in RUN or PAUSE.
- `done`  out  1  one-cycle pulse when `out_data` reaches `term_val`.
- `chg`  out  1  one-cycle pulse, registered one cycle after any change of `out_data[0]`.
- `done_cnt`  out  8  number of completed runs, saturating at 255.

## Operation
- States: IDLE (reset state), RUN, PAUSE, DONE.
- Reset values: state IDLE; `out_data` 0; `busy`, `done`, `chg` 0; `done_cnt` 0; prescaler 0.
- Input priority on any edge: `stop` > `start` > `pause`.
- `start` in IDLE, DONE or RUN:
  - `out_data` <= `start_val`, prescaler cleared, state RUN.
  - A restart in RUN is legal.
  - `start` in PAUSE is ignored.
- In RUN, with `pause`=0:
  - Prescaler counts 0..`DIV`-1.
  - On the edge where it wraps, `out_data` increments by 1, modulo 2^WIDTH.
  - If `term_val` < `start_val`, the count wraps through 0.
- Terminal: when an increment makes `out_data` equal `term_val`:
  - `done` is high for the following cycle.
  - `done_cnt` increments.
  - Next state follows the Configuration rule.
- `start_val` equal to `term_val`: the run completes immediately. `done` is asserted the cycle after `start`, with no increment.
- `pause`=1 in RUN:
  - Next state PAUSE; prescaler and `out_data` hold.
  - Returning to RUN when `pause` falls resumes the prescaler from its held value.
- `stop` in RUN or PAUSE: next state IDLE; `out_data` holds its value. `stop` in IDLE or DONE has no effect.
- `chg`: registered compare of `out_data[0]` against its previous value, active in every state.

## Timing
- `start` sampled at edge N: `busy`=1 and `out_data`=`start_val` after edge N.
- First increment at edge N+`DIV`.
- Terminal reached at edge M: `out_data`=`term_val` and `done`=1 after edge M; `done` clears after M+1.
- `chg` follows the `out_data[0]` toggle by exactly one cycle.
- `rstn` low during a run: all outputs return to their reset values immediately. On `rstn` release the block stays in IDLE.

## Configuration
- Macro: `COUNT_RUN_CTRL_AUTORELOAD_EN`.
- Defined:
  - At terminal, state stays RUN.
  - On the next prescaler wrap, `out_data` reloads the `start_val` captured at `start`, then counting continues.
  - `done` pulses once per lap; `done_cnt` counts laps.
- Undefined:
  - At terminal, state goes to DONE, `busy` falls and `out_data` holds `term_val`.
  - `done_cnt` still counts completed runs.

## Structure
- Package `count_run_ctrl_pkg`: state enum (IDLE, RUN, PAUSE, DONE), default `WIDTH` and default terminal constant `8'hFF`.
- Sub-module `count_run_tick`: the `DIV` prescaler with clear and hold inputs and a one-cycle tick output.

## Test plan
- `DIV`=1, `start_val`=0x00, `term_val`=0xFF, `start` at edge N -> `out_data`=0xFF and `done`=1 after edge N+255; `chg` pulses 255 times; `done_cnt`=1; state DONE.
- `DIV`=4, `start_val`=0x10, `term_val`=0x12 -> increments at N+4 and N+8; `done` after N+8.
- `start_val`=0xFE, `term_val`=0x01 -> sequence FE, FF, 00, 01; `done` when `out_data` reaches 0x01.
- `pause` high for 10 cycles mid-run with `DIV`=4 and the prescaler at 2 -> no increment while paused; next increment 2 cycles after `pause` falls.
- `stop` and `start` asserted on the same edge during RUN -> IDLE, `out_data` held, no `done`. `rstn` pulsed low mid-run -> `out_data`=0 and `busy`=0 immediately.
- With `COUNT_RUN_CTRL_AUTORELOAD_EN` defined, `start_val`=0x00, `term_val`=0x03, `DIV`=1 -> `done` every 4 cycles; `done_cnt` reaches 3 after 3 laps; `busy` stays 1.

Source files
------------

// File: rtl/count_run_ctrl_pkg.sv
// Shared state type and default constants for the count_run_ctrl run controller.
package count_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int         DEFAULT_WIDTH = 8;
  localparam logic [7:0] DEFAULT_TERM  = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/count_run_ctrl_if.sv
// Control/status bundle between a run-control master and count_run_ctrl (slave).
interface count_run_ctrl_if import count_run_ctrl_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic             stop;
  logic             pause;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;
  logic             chg;
  logic [7:0]       done_cnt;

  modport master (
    output start, stop, pause, start_val, term_val,
    input  out_data, busy, done, chg, done_cnt
  );

  modport slave (
    input  start, stop, pause, start_val, term_val,
    output out_data, busy, done, chg, done_cnt
  );

endinterface

// File: rtl/count_run_tick.sv
// DIV prescaler: counts 0..DIV-1 while enabled, holds otherwise, tick_o marks the wrap edge.
module count_run_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/count_run_ctrl.sv
// Run controller for the prescaled up-counter: start/pause/stop sequencing, terminal detect, chg/done events.
// Optional lap mode under `COUNT_RUN_CTRL_AUTORELOAD_EN: reload start_val after each terminal and keep running.
module count_run_ctrl import count_run_ctrl_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  count_run_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] step_val;
  logic             done_q, done_d;
  logic [7:0]       dcnt_q, dcnt_d;
  logic             prev_q, chg_q;
  logic             active, stop_act, start_act, run_act;
  logic             pre_clr, pre_en, tick;
`ifdef COUNT_RUN_CTRL_AUTORELOAD_EN
  logic [WIDTH-1:0] sv_q, sv_d;
`endif

  // Priority stop > start > pause; start is ignored while paused.
  assign active    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign stop_act  = bus.stop && active;
  assign start_act = bus.start && (state_q != ST_PAUSE) && !stop_act;
  assign run_act   = active && !bus.pause && !stop_act && !start_act;
  assign pre_clr   = stop_act || start_act;
  assign pre_en    = run_act;

  count_run_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (pre_clr),
    .en_i   (pre_en),
    .tick_o (tick)
  );

  always_comb begin
    step_val = out_q + WIDTH'(1);
`ifdef COUNT_RUN_CTRL_AUTORELOAD_EN
    if (out_q == bus.term_val) step_val = sv_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    done_d  = 1'b0;
    dcnt_d  = dcnt_q;
`ifdef COUNT_RUN_CTRL_AUTORELOAD_EN
    sv_d    = sv_q;
`endif
    if (stop_act) begin
      state_d = ST_IDLE;
    end else if (start_act) begin
      out_d   = bus.start_val;
      state_d = ST_RUN;
`ifdef COUNT_RUN_CTRL_AUTORELOAD_EN
      sv_d    = bus.start_val;
`endif
      if (bus.start_val == bus.term_val) begin
        done_d = 1'b1;
        dcnt_d = sat_inc8(dcnt_q);
`ifndef COUNT_RUN_CTRL_AUTORELOAD_EN
        state_d = ST_DONE;
`endif
      end
    end else if (active) begin
      if (bus.pause) begin
        state_d = ST_PAUSE;
      end else begin
        state_d = ST_RUN;
        if (tick) begin
          out_d = step_val;
          if (step_val == bus.term_val) begin
            done_d = 1'b1;
            dcnt_d = sat_inc8(dcnt_q);
`ifndef COUNT_RUN_CTRL_AUTORELOAD_EN
            state_d = ST_DONE;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      done_q  <= 1'b0;
      dcnt_q  <= '0;
      prev_q  <= 1'b0;
      chg_q   <= 1'b0;
`ifdef COUNT_RUN_CTRL_AUTORELOAD_EN
      sv_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      done_q  <= done_d;
      dcnt_q  <= dcnt_d;
      prev_q  <= out_q[0];
      chg_q   <= out_q[0] ^ prev_q;
`ifdef COUNT_RUN_CTRL_AUTORELOAD_EN
      sv_q    <= sv_d;
`endif
    end
  end

  assign bus.out_data = out_q;
  assign bus.busy     = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign bus.done     = done_q;
  assign bus.chg      = chg_q;
  assign bus.done_cnt = dcnt_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
// Bench for count_run_ctrl: DIV=1 and DIV=4 instances share stimulus and are scored against a run-level model.
`timescale 1ns/1ps
module tb_count_run_ctrl;
  import count_run_ctrl_pkg::*;

`ifdef COUNT_RUN_CTRL_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic [7:0] sv = 8'h00, tv = 8'h00;

  always #5 clk = ~clk;

  count_run_ctrl_if #(.WIDTH(8)) if1 ();
  count_run_ctrl_if #(.WIDTH(8)) if4 ();

  assign if1.start = start;  assign if4.start = start;
  assign if1.stop  = stop;   assign if4.stop  = stop;
  assign if1.pause = pause;  assign if4.pause = pause;
  assign if1.start_val = sv; assign if4.start_val = sv;
  assign if1.term_val  = tv; assign if4.term_val  = tv;

  count_run_ctrl #(.WIDTH(8), .DIV(1)) u_dut1 (.clk(clk), .rstn(rstn), .bus(if1.slave));
  count_run_ctrl #(.WIDTH(8), .DIV(4)) u_dut4 (.clk(clk), .rstn(rstn), .bus(if4.slave));

  int n_chk = 0, n_pass = 0;

  // Reference: per instance mode, count value, clocks elapsed toward next step, events and lap total.
  int divs [2] = '{1, 4};
  int m_mode[2], m_out[2], m_ph[2], m_cnt[2], m_sr[2];
  bit m_done[2], m_chg[2], m_prev[2];

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_out[i] = 0; m_ph[i] = 0; m_cnt[i] = 0; m_sr[i] = 0;
      m_done[i] = 0; m_chg[i] = 0; m_prev[i] = 0;
    end
  endtask

  task automatic finish_lap(input int i);
    m_done[i] = 1;
    if (m_cnt[i] < 255) m_cnt[i]++;
    if (!AUTO) m_mode[i] = M_DONE;
  endtask

  task automatic model_step(input int i);
    bit running;
    running   = (m_mode[i] == M_RUN) || (m_mode[i] == M_PAUSE);
    m_chg[i]  = ((m_out[i] % 2) != m_prev[i]);
    m_prev[i] = bit'(m_out[i] % 2);
    m_done[i] = 0;
    if (stop && running) begin
      m_mode[i] = M_IDLE;
    end else if (start && m_mode[i] != M_PAUSE) begin
      m_out[i] = sv; m_sr[i] = sv; m_ph[i] = 0; m_mode[i] = M_RUN;
      if (sv == tv) finish_lap(i);
    end else if (running) begin
      if (pause) m_mode[i] = M_PAUSE;
      else begin
        m_mode[i] = M_RUN;
        m_ph[i]++;
        if (m_ph[i] == divs[i]) begin
          m_ph[i] = 0;
          if (AUTO && m_out[i] == int'(tv)) m_out[i] = m_sr[i];
          else m_out[i] = (m_out[i] + 1) % 256;
          if (m_out[i] == int'(tv)) finish_lap(i);
        end
      end
    end
  endtask

  task automatic compare(input int i);
    int o, b, d, g, c;
    if (i == 0) begin
      o = if1.out_data; b = if1.busy; d = if1.done; g = if1.chg; c = if1.done_cnt;
    end else begin
      o = if4.out_data; b = if4.busy; d = if4.done; g = if4.chg; c = if4.done_cnt;
    end
    chk($sformatf("div%0d_out", divs[i]), o, m_out[i]);
    chk($sformatf("div%0d_busy", divs[i]), b, int'(m_mode[i] == M_RUN || m_mode[i] == M_PAUSE));
    chk($sformatf("div%0d_done", divs[i]), d, int'(m_done[i]));
    chk($sformatf("div%0d_chg", divs[i]), g, int'(m_chg[i]));
    chk($sformatf("div%0d_dcnt", divs[i]), c, m_cnt[i]);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rstn) begin model_step(0); model_step(1); end
    @(negedge clk);
    compare(0); compare(1);
  endtask

  task automatic do_reset();
    start = 0; stop = 0; pause = 0;
    rstn = 0; model_reset();
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask

  task automatic pulse_start();
    start = 1; cycle(); start = 0;
  endtask

  initial begin
    int nchg;

    do_reset();
    chk("rst_out1", if1.out_data, 0); chk("rst_busy1", if1.busy, 0);
    chk("rst_done4", if4.done, 0);    chk("rst_chg4", if4.chg, 0);
    chk("rst_dcnt4", if4.done_cnt, 0);

    // Full 0x00..0xFF sweep at DIV=1.
    sv = 8'h00; tv = DEFAULT_TERM;
    pulse_start();
    chk("sweep_busy", if1.busy, 1);
    nchg = 0;
    for (int k = 1; k <= 255; k++) begin cycle(); nchg += int'(if1.chg); end
    chk("sweep_out", if1.out_data, 255);
    chk("sweep_done", if1.done, 1);
    chk("sweep_dcnt", if1.done_cnt, 1);
    cycle(); nchg += int'(if1.chg);
    chk("sweep_chg_pulses", nchg, 255);
    chk("sweep_busy_end", if1.busy, AUTO ? 1 : 0);

    // DIV=4 short run 0x10 -> 0x12.
    do_reset();
    sv = 8'h10; tv = 8'h12;
    pulse_start();
    chk("div4_n0", if4.out_data, 8'h10);
    repeat (3) cycle();
    chk("div4_n3", if4.out_data, 8'h10);
    cycle();
    chk("div4_n4", if4.out_data, 8'h11);
    repeat (4) cycle();
    chk("div4_n8", if4.out_data, 8'h12);
    chk("div4_n8_done", if4.done, 1);

    // Wrap through zero at DIV=1.
    do_reset();
    sv = 8'hFE; tv = 8'h01;
    pulse_start();
    chk("wrap_fe", if1.out_data, 8'hFE);
    cycle(); chk("wrap_ff", if1.out_data, 8'hFF);
    cycle(); chk("wrap_00", if1.out_data, 8'h00); chk("wrap_00_done", if1.done, 0);
    cycle(); chk("wrap_01", if1.out_data, 8'h01); chk("wrap_01_done", if1.done, 1);

    // Pause for 10 cycles with the DIV=4 prescaler at 2.
    do_reset();
    sv = 8'h20; tv = 8'h40;
    pulse_start();
    repeat (2) cycle();
    pause = 1;
    repeat (10) cycle();
    chk("pause_hold", if4.out_data, 8'h20);
    chk("pause_busy", if4.busy, 1);
    pause = 0;
    cycle(); chk("resume_n1", if4.out_data, 8'h20);
    cycle(); chk("resume_n2", if4.out_data, 8'h21);

    // stop and start on the same edge: stop wins.
    stop = 1; start = 1; sv = 8'h55;
    cycle();
    stop = 0; start = 0;
    chk("stopstart_out", if4.out_data, 8'h21);
    chk("stopstart_busy", if4.busy, 0);
    cycle();
    chk("stopstart_done", if4.done, 0);
    chk("stopstart_hold", if4.out_data, 8'h21);

    // Asynchronous reset in the middle of a run.
    sv = 8'h30; tv = 8'h80;
    pulse_start();
    repeat (5) cycle();
    rstn = 0;
    #1;
    chk("arst_out4", if4.out_data, 0); chk("arst_busy4", if4.busy, 0);
    chk("arst_out1", if1.out_data, 0); chk("arst_busy1", if1.busy, 0);
    model_reset();
    @(negedge clk);
    rstn = 1;
    cycle();
    chk("arst_idle", if1.busy, 0);

`ifdef COUNT_RUN_CTRL_AUTORELOAD_EN
    // Laps of 0..3 at DIV=1.
    do_reset();
    sv = 8'h00; tv = 8'h03;
    pulse_start();
    for (int k = 1; k <= 12; k++) begin
      cycle();
      chk($sformatf("lap_done_k%0d", k), if1.done, int'((k % 4) == 3));
    end
    chk("lap_dcnt", if1.done_cnt, 3);
    chk("lap_busy", if1.busy, 1);
`endif

    // Random control traffic against the model.
    do_reset();
    tv = 8'h40; sv = 8'h38;
    for (int k = 0; k < 2500; k++) begin
      if (m_mode[0] != M_RUN && m_mode[0] != M_PAUSE &&
          m_mode[1] != M_RUN && m_mode[1] != M_PAUSE && $urandom_range(0, 3) == 0)
        tv = 8'($urandom);
      sv    = tv - 8'($urandom_range(0, 10));
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      cycle();
    end
    start = 0; stop = 0; pause = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
